// File: rtl/layer_addr_gen_if.sv
// Read-beat bus from layer_addr_gen to the layer RAMs: dual-bank addresses, accumulator framing, output index.
// Master drives valid/payload, slave returns ready; payload is held while valid && !ready.
interface layer_addr_gen_if #(
    parameter int ADDR_W = 10,
    parameter int OUT_AW = 10
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic              first_tap;
    logic              last_tap;
    logic [OUT_AW-1:0] out_idx;

    modport master (
        output valid, addr1, addr2, first_tap, last_tap, out_idx,
        input  ready
    );

    modport slave (
        input  valid, addr1, addr2, first_tap, last_tap, out_idx,
        output ready
    );
endinterface

// File: rtl/layer_addr_gen.sv
// K x K strided window read-address sequencer over a planar multi-channel map; ADDR_GEN_LINEAR_EN adds a flat sweep.
// Latency: first beat the cycle after start is taken, then one beat per cycle; done pulses the cycle after the last accept.
// Backpressure: counters and outputs hold while ready is low; start is ignored outside IDLE.
module layer_addr_gen #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int CHANNELS    = 1,
    parameter int K           = 5,
    parameter int STRIDE      = 1,
    parameter int BANK_OFFSET = 0,
    parameter int ADDR_W      = 10,
    parameter int OUT_AW      = 10
`ifdef ADDR_GEN_LINEAR_EN
    ,
    parameter int LIN_LEN     = 25
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef ADDR_GEN_LINEAR_EN
    input  logic              mode,
`endif
    layer_addr_gen_if.master  bus,
    output logic              busy,
    output logic              done
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

    localparam logic [31:0] KM1  = 32'(K - 1);
    localparam logic [31:0] CM1  = 32'(CHANNELS - 1);
    localparam logic [31:0] OWM1 = 32'(OUT_W - 1);
    localparam logic [31:0] OHM1 = 32'(OUT_H - 1);

    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] COL_STEP   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] WROW_STEP  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] BANK_OFF   = ADDR_W'(BANK_OFFSET);
    localparam logic [OUT_AW-1:0] ONE_O      = OUT_AW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [31:0]       kx, ky, c, ox, oy;
    logic [ADDR_W-1:0] addr_r, row_base, ch_base, win_base, wrow_base;
    logic [OUT_AW-1:0] out_r;

    logic lin_sel, lin_last;
    logic win_first, win_last;
    logic tap_first, tap_last, sweep_last;

`ifdef ADDR_GEN_LINEAR_EN
    localparam logic [31:0] LM1 = 32'(LIN_LEN - 1);
    logic mode_r;
    assign lin_sel  = mode_r;
    assign lin_last = (kx == LM1);
`else
    assign lin_sel  = 1'b0;
    assign lin_last = 1'b0;
`endif

    assign win_first  = (c == '0) && (ky == '0) && (kx == '0);
    assign win_last   = (c == CM1) && (ky == KM1) && (kx == KM1);
    assign tap_first  = lin_sel ? (kx == '0) : win_first;
    assign tap_last   = lin_sel ? lin_last : win_last;
    assign sweep_last = lin_sel ? lin_last : (win_last && (ox == OWM1) && (oy == OHM1));

    assign busy          = (state == RUN);
    assign done          = (state == DONE);
    assign bus.valid     = busy;
    assign bus.addr1     = addr_r;
    assign bus.addr2     = busy ? addr_r + BANK_OFF : '0;
    assign bus.first_tap = busy && tap_first;
    assign bus.last_tap  = busy && tap_last;
    assign bus.out_idx   = out_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
`ifdef ADDR_GEN_LINEAR_EN
            mode_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
`ifdef ADDR_GEN_LINEAR_EN
                    mode_r <= mode;
`endif
                end
                RUN:     if (bus.ready && sweep_last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end

        // Counters live only in RUN; every other cycle forces them back to the sweep origin.
        if (reset || state != RUN) begin
            kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0;
            addr_r <= '0; row_base <= '0; ch_base <= '0; win_base <= '0; wrow_base <= '0;
            out_r <= '0;
        end else if (bus.ready && !sweep_last) begin
            if (lin_sel || kx != KM1) begin
                kx     <= kx + 32'd1;
                addr_r <= addr_r + ONE_A;
            end else if (ky != KM1) begin
                kx       <= '0;
                ky       <= ky + 32'd1;
                row_base <= row_base + ROW_STEP;
                addr_r   <= row_base + ROW_STEP;
            end else if (c != CM1) begin
                kx       <= '0;
                ky       <= '0;
                c        <= c + 32'd1;
                ch_base  <= ch_base + PLANE_STEP;
                row_base <= ch_base + PLANE_STEP;
                addr_r   <= ch_base + PLANE_STEP;
            end else begin
                kx    <= '0;
                ky    <= '0;
                c     <= '0;
                out_r <= out_r + ONE_O;
                if (ox != OWM1) begin
                    ox       <= ox + 32'd1;
                    win_base <= win_base + COL_STEP;
                    ch_base  <= win_base + COL_STEP;
                    row_base <= win_base + COL_STEP;
                    addr_r   <= win_base + COL_STEP;
                end else begin
                    ox        <= '0;
                    oy        <= oy + 32'd1;
                    wrow_base <= wrow_base + WROW_STEP;
                    win_base  <= wrow_base + WROW_STEP;
                    ch_base   <= wrow_base + WROW_STEP;
                    row_base  <= wrow_base + WROW_STEP;
                    addr_r    <= wrow_base + WROW_STEP;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer_addr_gen.sv
// Directed bench for layer_addr_gen: three window geometries (conv 28x28 K5, pool 24x24 K2 S2, 2-channel 4x4 K3).
module tb_layer_addr_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic rdy = 1'b1;
    int   sel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    layer_addr_gen_if #(.ADDR_W(10), .OUT_AW(10)) ifa ();
    layer_addr_gen_if #(.ADDR_W(10), .OUT_AW(10)) ifb ();
    layer_addr_gen_if #(.ADDR_W(10), .OUT_AW(10)) ifc ();

    assign ifa.ready = rdy;
    assign ifb.ready = rdy;
    assign ifc.ready = rdy;

    logic st_a, st_b, st_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    assign st_a = start && (sel == 0);
    assign st_b = start && (sel == 1);
    assign st_c = start && (sel == 2);

`ifdef ADDR_GEN_LINEAR_EN
    logic mode = 1'b0;
    logic st_d, busy_d, done_d;
    assign st_d = start && (sel == 3);
    layer_addr_gen_if #(.ADDR_W(10), .OUT_AW(10)) ifd ();
    assign ifd.ready = rdy;
    layer_addr_gen #(.IMG_W(28), .IMG_H(28), .CHANNELS(1), .K(5), .STRIDE(1), .BANK_OFFSET(25),
                     .ADDR_W(10), .OUT_AW(10), .LIN_LEN(25))
        u_d (.clk(clk), .reset(reset), .start(st_d), .mode(mode), .bus(ifd), .busy(busy_d), .done(done_d));
`endif

    layer_addr_gen #(.IMG_W(28), .IMG_H(28), .CHANNELS(1), .K(5), .STRIDE(1), .BANK_OFFSET(0),
                     .ADDR_W(10), .OUT_AW(10))
        u_a (.clk(clk), .reset(reset), .start(st_a),
`ifdef ADDR_GEN_LINEAR_EN
             .mode(1'b0),
`endif
             .bus(ifa), .busy(busy_a), .done(done_a));

    layer_addr_gen #(.IMG_W(24), .IMG_H(24), .CHANNELS(1), .K(2), .STRIDE(2), .BANK_OFFSET(0),
                     .ADDR_W(10), .OUT_AW(10))
        u_b (.clk(clk), .reset(reset), .start(st_b),
`ifdef ADDR_GEN_LINEAR_EN
             .mode(1'b0),
`endif
             .bus(ifb), .busy(busy_b), .done(done_b));

    layer_addr_gen #(.IMG_W(4), .IMG_H(4), .CHANNELS(2), .K(3), .STRIDE(1), .BANK_OFFSET(100),
                     .ADDR_W(10), .OUT_AW(10))
        u_c (.clk(clk), .reset(reset), .start(st_c),
`ifdef ADDR_GEN_LINEAR_EN
             .mode(1'b0),
`endif
             .bus(ifc), .busy(busy_c), .done(done_c));

    // Selected DUT's outputs, so one checker drives every geometry.
    logic [9:0] o_a1, o_a2, o_idx;
    logic       o_v, o_ft, o_lt, o_busy, o_done;
    always_comb begin
        o_a1 = '0; o_a2 = '0; o_idx = '0; o_v = 1'b0; o_ft = 1'b0; o_lt = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        case (sel)
            0: begin o_a1 = ifa.addr1; o_a2 = ifa.addr2; o_idx = ifa.out_idx; o_v = ifa.valid;
                     o_ft = ifa.first_tap; o_lt = ifa.last_tap; o_busy = busy_a; o_done = done_a; end
            1: begin o_a1 = ifb.addr1; o_a2 = ifb.addr2; o_idx = ifb.out_idx; o_v = ifb.valid;
                     o_ft = ifb.first_tap; o_lt = ifb.last_tap; o_busy = busy_b; o_done = done_b; end
            2: begin o_a1 = ifc.addr1; o_a2 = ifc.addr2; o_idx = ifc.out_idx; o_v = ifc.valid;
                     o_ft = ifc.first_tap; o_lt = ifc.last_tap; o_busy = busy_c; o_done = done_c; end
`ifdef ADDR_GEN_LINEAR_EN
            3: begin o_a1 = ifd.addr1; o_a2 = ifd.addr2; o_idx = ifd.out_idx; o_v = ifd.valid;
                     o_ft = ifd.first_tap; o_lt = ifd.last_tap; o_busy = busy_d; o_done = done_d; end
`endif
            default: ;
        endcase
    end

    int q_a1[$], q_a2[$], q_idx[$], q_ft[$], q_lt[$];
    int nv;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Walks the reference loop order with ready held high, optionally stalling at one beat or resetting at another.
    task automatic run_window(input string tag, input int W, input int H, input int C, input int K,
                              input int S, input int BO, input int stall_at, input int abort_at);
        int ow, oh, i, err, a;
        ow = (W - K) / S + 1;
        oh = (H - K) / S + 1;
        i = 0; err = 0; nv = 0;
        q_a1.delete(); q_a2.delete(); q_idx.delete(); q_ft.delete(); q_lt.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < C; c++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            a = c*W*H + (oy*S + ky)*W + ox*S + kx;
                            if (o_v === 1'b1) nv++;
                            if (o_v !== 1'b1 || o_a1 !== 10'(a) || o_a2 !== 10'(a + BO) ||
                                o_idx !== 10'(oy*ow + ox) ||
                                o_ft !== (c == 0 && ky == 0 && kx == 0) ||
                                o_lt !== (c == C-1 && ky == K-1 && kx == K-1)) err++;
                            q_a1.push_back(int'(o_a1)); q_a2.push_back(int'(o_a2));
                            q_idx.push_back(int'(o_idx));
                            q_ft.push_back(int'(o_ft)); q_lt.push_back(int'(o_lt));
                            if (i == abort_at) begin
                                check({tag, " stream before reset"}, err, 0);
                                reset = 1'b1;
                                @(negedge clk);
                                check({tag, " reset valid"}, int'(o_v), 0);
                                check({tag, " reset addr1"}, int'(o_a1), 0);
                                check({tag, " reset done"}, int'(o_done), 0);
                                reset = 1'b0;
                                @(negedge clk);
                                check({tag, " no done after reset"}, int'(o_done), 0);
                                return;
                            end
                            if (i == stall_at) begin
                                rdy = 1'b0;
                                start = 1'b1;
                                for (int s = 0; s < 3; s++) begin
                                    @(negedge clk);
                                    check({tag, " stall addr1"}, int'(o_a1), a);
                                    check({tag, " stall valid"}, int'(o_v), 1);
                                end
                                start = 1'b0;
                                rdy = 1'b1;
                            end
                            i++;
                            @(negedge clk);
                        end
        check({tag, " done pulse"}, int'(o_done), 1);
        check({tag, " valid in done"}, int'(o_v), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done one cycle"}, int'(o_done), 0);
        @(negedge clk);
        check({tag, " start in done ignored"}, int'(o_v), 0);
        check({tag, " stream"}, err, 0);
        check({tag, " beats"}, nv, ow*oh*C*K*K);
    endtask

    initial begin
        int exp_a[6];
        int exp_b[8];
        exp_a = '{0, 1, 2, 3, 4, 28};
        exp_b = '{0, 1, 24, 25, 2, 3, 26, 27};

        // Reset held with start asserted: reset must win.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset valid", int'(o_v), 0);
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_done), 0);
        check("reset first_tap", int'(o_ft), 0);
        check("reset last_tap", int'(o_lt), 0);
        check("reset addr1", int'(o_a1), 0);
        check("reset out_idx", int'(o_idx), 0);
        sel = 2;
        #1;
        check("reset addr2 offset bank", int'(o_a2), 0);
        start = 1'b0;
        reset = 1'b0;
        sel = 0;
        @(negedge clk);
        check("idle after reset", int'(o_v), 0);

        run_window("conv abort", 28, 28, 1, 5, 1, 0, -1, 50);
        run_window("conv", 28, 28, 1, 5, 1, 0, 7, -1);
        for (int j = 0; j < 6; j++) check("conv head addr1", q_a1[j], exp_a[j]);
        check("conv beat24 addr1", q_a1[24], 116);
        check("conv beat25 first_tap", q_ft[25], 1);
        check("conv beat25 out_idx", q_idx[25], 1);
        check("conv last addr1", q_a1[q_a1.size()-1], 783);
        check("conv last out_idx", q_idx[q_idx.size()-1], 575);

        sel = 1;
        run_window("pool", 24, 24, 1, 2, 2, 0, -1, -1);
        for (int j = 0; j < 8; j++) check("pool head addr1", q_a1[j], exp_b[j]);
        check("pool beat4 out_idx", q_idx[4], 1);
        check("pool beat2 last_tap", q_lt[2], 0);
        check("pool beat3 last_tap", q_lt[3], 1);
        check("pool beat7 last_tap", q_lt[7], 1);

        sel = 2;
        run_window("chan2", 4, 4, 2, 3, 1, 100, 30, -1);
        check("chan2 beat0 addr2", q_a2[0], 100);
        check("chan2 beat9 addr1", q_a1[9], 16);
        check("chan2 beat9 addr2", q_a2[9], 116);
        check("chan2 beat8 last_tap", q_lt[8], 0);
        check("chan2 beat17 last_tap", q_lt[17], 1);
        check("chan2 beat18 first_tap", q_ft[18], 1);

`ifdef ADDR_GEN_LINEAR_EN
        sel = 3;
        mode = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; mode = 1'b0;
        for (int j = 0; j < 25; j++) begin
            check("lin addr1", int'(o_a1), j);
            check("lin addr2", int'(o_a2), j + 25);
            check("lin out_idx", int'(o_idx), 0);
            check("lin first_tap", int'(o_ft), int'(j == 0));
            check("lin last_tap", int'(o_lt), int'(j == 24));
            @(negedge clk);
        end
        check("lin done", int'(o_done), 1);
        check("lin valid in done", int'(o_v), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_addr_gen.md
# layer_addr_gen

Parametrised read-address sequencer for the CNN layer memories: sweeps a K×K window with stride over a multi-channel feature map (convolution and pooling layers), or optionally does a flat linear sweep (kernel-weight and fully-connected weight memories). Drives two dual-port read addresses per beat (bank A and bank B = A + BANK_OFFSET) with accumulator framing flags and the destination output index. Sits between the layer controller and the image, pooled-map and weight RAMs, and replaces the per-layer fixed counters.

## Interface
- IMG_W, 28, input map width in pixels
- IMG_H, 28, input map height in pixels
- CHANNELS, 1, input channels, stored planar: channel c at base c·IMG_W·IMG_H
- K, 5, window side (1..IMG_W)
- STRIDE, 1, window step in x and y
- BANK_OFFSET, 0, constant added to addr1 to form addr2
- ADDR_W, 10, read address width
- OUT_AW, 10, out_idx width
- LIN_LEN, 25, beats in linear mode (only with ADDR_GEN_LINEAR_EN)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE
- mode  in  1  0 = window, 1 = linear (only with ADDR_GEN_LINEAR_EN)
- ready  in  1  consumer accepts current beat
- valid  out  1  addr1/addr2/flags hold a beat
- addr1  out  ADDR_W  bank-A read address
- addr2  out  ADDR_W  addr1 + BANK_OFFSET, modulo 2^ADDR_W
- first_tap  out  1  first beat of an output pixel (clear accumulator)
- last_tap  out  1  last beat of an output pixel (commit accumulator)
- out_idx  out  OUT_AW  output pixel index oy·OUT_W + ox
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at sweep end

## Operation
- Derived: OUT_W = (IMG_W−K)/STRIDE + 1, OUT_H = (IMG_H−K)/STRIDE + 1 (integer division).
- Window order, outer to inner: oy, ox, c, ky, kx. addr1 = c·IMG_W·IMG_H + (oy·STRIDE+ky)·IMG_W + ox·STRIDE + kx.
- Addresses built with incremental adders on registered bases (row base, window base, channel base); no multipliers.
- first_tap when c=ky=kx=0; last_tap when c=CHANNELS−1, ky=kx=K−1. K=1 and CHANNELS=1: both high every beat.
- Total window beats = OUT_W·OUT_H·CHANNELS·K·K.
- States: IDLE → (start) RUN → (last beat accepted) DONE → IDLE.
- IDLE: all counters zero, valid=0. start=1 loads mode and enters RUN.
- RUN: valid=1; counters advance only when valid&ready. Outputs stable while ready=0.
- DONE: valid=0, busy=0, done=1 for exactly one cycle; start ignored; then IDLE.
- start while RUN or DONE: ignored, no restart.
- Widths: addresses exceeding ADDR_W truncate; addr2 wraps silently. Parameter sizing is the integrator's responsibility.

## Timing
- Reset: state IDLE; valid, busy, done, first_tap, last_tap = 0; addr1, addr2, out_idx = 0 (addr2 = 0, not BANK_OFFSET).
- start high at edge n → valid=1 with first beat from edge n+1 (one-cycle latency).
- Beat advance: edge after valid&ready; one beat per cycle at ready=1 sustained.
- Last beat accepted at edge m → done=1 during cycle after m, valid=0 same cycle; start earliest accepted the cycle after done.
- reset asserted mid-RUN: IDLE at next edge, no done pulse, sweep discarded.
- reset and start same cycle: reset wins.

## Configuration
- ADDR_GEN_LINEAR_EN defined: mode port and LIN_LEN present. mode=1 sampled at start gives addr1 = 0..LIN_LEN−1, addr2 = addr1 + BANK_OFFSET, out_idx = 0, first_tap on beat 0, last_tap on beat LIN_LEN−1, then DONE.
- Undefined: no mode port, no linear logic; window sweep only.

## Test plan
- 28×28, K=5, S=1, C=1: addr1 0,1,2,3,4,28,29,…,116; 14400 beats; last addr1 783, out_idx 575; single done.
- Pool 24×24, K=2, S=2: window0 0,1,24,25; window1 2,3,26,27 out_idx 1; 576 beats; last_tap every 4th beat.
- C=2, 4×4, K=3, S=1, BANK_OFFSET=100: beat 9 addr1=16, addr2=116, last_tap on beat 17; 72 beats.
- ready low 3 cycles mid-sweep: addr1/flags frozen, no beat lost or duplicated; start pulses during RUN ignored.
- reset at beat 50: next cycle valid=0, addr1=0, no done; fresh start begins at addr1=0.
- Linear (ADDR_GEN_LINEAR_EN), LIN_LEN=25, BANK_OFFSET=25: addr1 0..24, addr2 25..49, done one cycle after beat 24.
